deconv_row_feeder: RTL and testbench
====================================

// Module: deconv_row_feeder
// PURPOSE
//  Producer side of the deconvolution row-accumulator interface (en_shift / data_strobe / data_in / accumn_fin).
//  Accepts one packed row of N_COL_FEATURE x N_COL_KERNEL partial products over a valid/ready handshake and holds it.
//  Walks a one-hot strobe across the feature columns while honouring the accumulator's accumn_fin busy window.
//  Completes the row before accepting the next one. Sits between the PE multiplier array and the row accumulator.
// PARAMETERS
//  BIT_WIDTH     8    pixel width; each packed product is 2*BIT_WIDTH bits
//  N_COL_FEATURE 8    feature columns per row = number of strobe steps per row
//  N_COL_KERNEL  5    kernel columns; products per feature column
//  NUM_STRIDE    2    deconv stride; passed through to the accumulator, not used internally
//  N_PIX_IN      N_COL_FEATURE*N_COL_KERNEL   products per row (derived)
//  STRB_WIDTH    2*BIT_WIDTH*N_PIX_IN/4       strobe bus width; must match the accumulator (derived)
//  DRAIN_TIMEOUT 64   max cycles spent in DRAIN waiting for accumn_fin before flagging an error
// PORTS
//  clk          in   1                     clock, all logic on rising edge
//  rst          in   1                     synchronous, active-high reset
//  s_valid      in   1                     upstream row valid
//  s_ready      out  1                     feeder can accept a row
//  s_data       in   2*BIT_WIDTH*N_PIX_IN  packed row; column c occupies [c*2*BIT_WIDTH*N_COL_KERNEL +: 2*BIT_WIDTH*N_COL_KERNEL]
//  en_shift     out  1                     strobe step valid to accumulator
//  data_strobe  out  STRB_WIDTH            one-hot column select; only bits [N_COL_FEATURE-1:0] ever set
//  data_in      out  2*BIT_WIDTH*N_PIX_IN  held row to accumulator
//  accumn_fin   in   1                     accumulator busy/row-finished window
//  busy         out  1                     state != IDLE
//  row_cnt      out  16                    rows completed; wraps 0xFFFF -> 0
//  err          out  1                     sticky DRAIN timeout flag; cleared only by rst
// BEHAVIOUR
//  Reset (sync, rst=1 at clk edge): state=IDLE, col=0, en_shift=0, data_strobe=0, data_in=0, row_cnt=0, err=0.
//   s_ready=0 while rst is high.
//  Outputs en_shift, data_strobe and data_in are registered. s_ready = (state==IDLE) & ~rst.
//  FSM IDLE -> SHIFT -> DRAIN -> HOLD -> IDLE:
//   IDLE : on s_valid & s_ready at edge N: data_in<=s_data, col<=0 -> SHIFT.
//          data_in changes only on an accept edge.
//   SHIFT: each cycle with accumn_fin=0: en_shift=1, data_strobe=1<<col, col++.
//          After issuing col=N_COL_FEATURE-1 -> DRAIN.
//          accumn_fin=1 in SHIFT: stall; en_shift=0, data_strobe=0, col frozen; resume the same col when it drops.
//          No strobe step is ever skipped or repeated.
//   DRAIN: en_shift=0, data_strobe=0; count cycles.
//          accumn_fin=1 -> HOLD.
//          Count reaches DRAIN_TIMEOUT -> err<=1, -> IDLE, row_cnt unchanged.
//   HOLD : wait for accumn_fin=0 -> row_cnt++, -> IDLE.
//  Latency: accept at edge N -> strobe bit0 with en_shift visible cycle N+1.
//   With no stalls, bit k is issued in cycle N+1+k; the last step is in cycle N+N_COL_FEATURE.
//  Exactly one data_strobe bit is high whenever en_shift=1; data_strobe=0 whenever en_shift=0.
//  Simultaneous accumn_fin=1 and the last SHIFT step: stall wins; the step is issued after accumn_fin drops.
//  s_valid with s_ready=0: ignored; upstream must hold s_valid/s_data (standard valid/ready).
//  rst mid-row: row discarded; next cycle all outputs at reset values; no partial row_cnt increment.
//  HOLD->IDLE and a new accept can occur on consecutive edges; minimum row period = N_COL_FEATURE+3 cycles.
// TESTING
//  1 rst high 3 cycles -> s_ready=0, en_shift=0, data_in=0, row_cnt=0, err=0.
//    Cycle after release: s_ready=1.
//  2 Accept row (col c bytes = c), stub raises accumn_fin 1 cycle after the last step for 5 cycles
//    -> data_strobe 0x01,0x02,...,0x80 in 8 consecutive cycles with en_shift=1.
//    -> s_ready=1 the cycle after accumn_fin falls; row_cnt=1.
//  3 Force accumn_fin=1 for 3 cycles while data_strobe=0x08 is next
//    -> en_shift=0 for 3 cycles, then 0x08,0x10,... resume; 8 steps total.
//  4 s_valid held high with rows A,B -> B accepted on the first IDLE cycle after A completes.
//    data_in==A throughout A's steps; row_cnt=2.
//  5 DRAIN_TIMEOUT=16, accumn_fin tied 0 -> err=1 after 16 DRAIN cycles.
//    State returns to IDLE; row_cnt=0; err stays 1 until rst.
//  6 rst pulse while data_strobe=0x04 -> next cycle en_shift=0, data_strobe=0, data_in=0, busy=0.
//    A fresh row then replays from 0x01.

Source files
------------

// File: rtl/deconv_row_feeder.sv
// Row feeder for the deconvolution row accumulator.
// Takes one packed row over valid/ready, holds it on data_in, then steps a
// one-hot strobe across the feature columns. Steps pause while accumn_fin is
// high. After the last step it waits for the accumulator to finish the row.
module deconv_row_feeder #(
    parameter int BIT_WIDTH     = 8,
    parameter int N_COL_FEATURE = 8,
    parameter int N_COL_KERNEL  = 5,
    parameter int NUM_STRIDE    = 2,
    parameter int N_PIX_IN      = N_COL_FEATURE * N_COL_KERNEL,
    parameter int STRB_WIDTH    = 2 * BIT_WIDTH * N_PIX_IN / 4,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [2*BIT_WIDTH*N_PIX_IN-1:0] s_data,
    output logic                            en_shift,
    output logic [STRB_WIDTH-1:0]           data_strobe,
    output logic [2*BIT_WIDTH*N_PIX_IN-1:0] data_in,
    input  logic                            accumn_fin,
    output logic                            busy,
    output logic [15:0]                     row_cnt,
    output logic                            err
);

    localparam int DW = 2 * BIT_WIDTH * N_PIX_IN;
    localparam int CW = (N_COL_FEATURE > 1) ? $clog2(N_COL_FEATURE) : 1;
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    // NUM_STRIDE is only carried for the accumulator; sanity-check the geometry here.
    if (NUM_STRIDE < 1 || STRB_WIDTH < N_COL_FEATURE || N_PIX_IN != N_COL_FEATURE * N_COL_KERNEL
        || DRAIN_TIMEOUT < 1) begin : g_bad_params
        $error("deconv_row_feeder: inconsistent parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [TW-1:0]           drain_q, drain_d;
    logic                    en_shift_q, en_shift_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic [DW-1:0]           data_q, data_d;
    logic [15:0]             row_cnt_q, row_cnt_d;
    logic                    err_q, err_d;

    assign s_ready     = (state_q == S_IDLE) & ~rst;
    assign busy        = (state_q != S_IDLE);
    assign en_shift    = en_shift_q;
    assign data_strobe = strb_q;
    assign data_in     = data_q;
    assign row_cnt     = row_cnt_q;
    assign err         = err_q;

    // Next-state and next-output logic for the row walk.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        drain_d    = drain_q;
        en_shift_d = 1'b0;
        strb_d     = '0;
        data_d     = data_q;
        row_cnt_d  = row_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    data_d  = s_data;
                    col_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!accumn_fin) begin
                    en_shift_d     = 1'b1;
                    strb_d[col_q]  = 1'b1;
                    if (col_q == CW'(N_COL_FEATURE - 1)) begin
                        col_d   = '0;
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (accumn_fin) begin
                    state_d = S_HOLD;
                end else if (drain_q == TW'(DRAIN_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (!accumn_fin) begin
                    row_cnt_d = row_cnt_q + 16'd1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            drain_q    <= '0;
            en_shift_q <= 1'b0;
            strb_q     <= '0;
            data_q     <= '0;
            row_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            drain_q    <= drain_d;
            en_shift_q <= en_shift_d;
            strb_q     <= strb_d;
            data_q     <= data_d;
            row_cnt_q  <= row_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_deconv_row_feeder.sv
// Directed bench for deconv_row_feeder: table-driven strobe sequences plus
// hand-written sequences for back-to-back rows, drain timeout and mid-row reset.
module tb_deconv_row_feeder;

    localparam int BW   = 8;
    localparam int NF   = 8;
    localparam int NK   = 5;
    localparam int DW   = 2 * BW * NF * NK;
    localparam int SW   = DW / 4;
    localparam int COLW = 2 * BW * NK;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          en_shift;
    logic [SW-1:0] data_strobe;
    logic [DW-1:0] data_in;
    logic          accumn_fin;
    logic          busy;
    logic [15:0]   row_cnt;
    logic          err;

    deconv_row_feeder #(
        .BIT_WIDTH    (BW),
        .N_COL_FEATURE(NF),
        .N_COL_KERNEL (NK),
        .NUM_STRIDE   (2),
        .DRAIN_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .en_shift   (en_shift),
        .data_strobe(data_strobe),
        .data_in    (data_in),
        .accumn_fin (accumn_fin),
        .busy       (busy),
        .row_cnt    (row_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fin;
        logic          en;
        logic [SW-1:0] strb;
        logic          ready;
    } vec_t;

    vec_t          tbl [0:63];
    int            ntbl;
    int            checks;
    int            errors;
    logic [DW-1:0] row_a, row_b, row_c;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fin, input logic en, input int bitn, input logic ready);
        tbl[ntbl].fin   = fin;
        tbl[ntbl].en    = en;
        tbl[ntbl].strb  = '0;
        if (bitn >= 0) tbl[ntbl].strb[bitn] = 1'b1;
        tbl[ntbl].ready = ready;
        ntbl++;
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            accumn_fin = tbl[i].fin;
            step();
            chk($sformatf("tbl[%0d].en_shift", i), DW'(en_shift), DW'(tbl[i].en));
            chk($sformatf("tbl[%0d].data_strobe", i), DW'(data_strobe), DW'(tbl[i].strb));
            chk($sformatf("tbl[%0d].s_ready", i), DW'(s_ready), DW'(tbl[i].ready));
        end
        accumn_fin = 1'b0;
    endtask

    task automatic accept(input logic [DW-1:0] d);
        chk("accept.s_ready_before", DW'(s_ready), DW'(1));
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
        chk("accept.data_in", data_in, d);
        chk("accept.busy", DW'(busy), DW'(1));
        chk("accept.en_shift", DW'(en_shift), DW'(0));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [DW-1:0] make_row(input int base);
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < NF; c++)
            for (int b = 0; b < COLW / 8; b++)
                r[c*COLW + b*8 +: 8] = 8'((c + base) & 8'hFF);
        return r;
    endfunction

    initial begin
        clk = 1'b0; rst = 1'b1; s_valid = 1'b0; s_data = '0; accumn_fin = 1'b0;
        checks = 0; errors = 0; ntbl = 0;
        row_a = make_row(0);
        row_b = make_row(8'h40);
        row_c = make_row(8'h90);

        // Test 2 table: straight walk, accumulator busy for 5 cycles after the last step.
        for (int k = 0; k < NF; k++) add(1'b0, 1'b1, k, 1'b0);
        for (int k = 0; k < 5; k++)  add(1'b1, 1'b0, -1, 1'b0);
        add(1'b0, 1'b0, -1, 1'b1);                                 // ends at 14
        // Test 3 table: stall 3 cycles with bit3 next.
        for (int k = 0; k < 3; k++)  add(1'b0, 1'b1, k, 1'b0);
        for (int k = 0; k < 3; k++)  add(1'b1, 1'b0, -1, 1'b0);
        for (int k = 3; k < NF; k++) add(1'b0, 1'b1, k, 1'b0);
        add(1'b0, 1'b0, -1, 1'b0);
        add(1'b1, 1'b0, -1, 1'b0);
        add(1'b0, 1'b0, -1, 1'b1);                                 // ends at 28
        // Stall coinciding with the last step: last step deferred.
        for (int k = 0; k < NF - 1; k++) add(1'b0, 1'b1, k, 1'b0);
        add(1'b1, 1'b0, -1, 1'b0);
        add(1'b1, 1'b0, -1, 1'b0);
        add(1'b0, 1'b1, NF - 1, 1'b0);
        add(1'b1, 1'b0, -1, 1'b0);
        add(1'b0, 1'b0, -1, 1'b1);                                 // ends at 40

        // Test 1: reset.
        rst = 1'b1;
        step(); step(); step();
        chk("rst.s_ready", DW'(s_ready), DW'(0));
        chk("rst.en_shift", DW'(en_shift), DW'(0));
        chk("rst.data_strobe", DW'(data_strobe), DW'(0));
        chk("rst.data_in", data_in, '0);
        chk("rst.row_cnt", DW'(row_cnt), DW'(0));
        chk("rst.err", DW'(err), DW'(0));
        chk("rst.busy", DW'(busy), DW'(0));
        rst = 1'b0;
        step();
        chk("post_rst.s_ready", DW'(s_ready), DW'(1));

        // Tests 2, 3 and last-step stall.
        accept(row_a);
        run_tbl(0, 14);
        chk("t2.row_cnt", DW'(row_cnt), DW'(1));
        chk("t2.data_in_held", data_in, row_a);
        accept(row_b);
        run_tbl(14, 28);
        chk("t3.row_cnt", DW'(row_cnt), DW'(2));
        accept(row_c);
        run_tbl(28, 40);
        chk("laststall.row_cnt", DW'(row_cnt), DW'(3));
        chk("laststall.err", DW'(err), DW'(0));

        // Test 4: s_valid held, B accepted on first IDLE cycle after A.
        do_reset(1);
        s_valid = 1'b1;
        s_data  = row_a;
        step();
        chk("t4.accept_a", data_in, row_a);
        s_data = row_b;
        for (int k = 0; k < NF; k++) begin
            step();
            chk($sformatf("t4.a_strobe%0d", k), DW'(data_strobe), DW'(SW'(1) << k));
            chk($sformatf("t4.a_data%0d", k), data_in, row_a);
        end
        accumn_fin = 1'b1;
        step();
        chk("t4.a_hold_data", data_in, row_a);
        accumn_fin = 1'b0;
        step();
        chk("t4.a_done_row_cnt", DW'(row_cnt), DW'(1));
        chk("t4.a_done_ready", DW'(s_ready), DW'(1));
        chk("t4.a_done_data", data_in, row_a);
        step();
        s_valid = 1'b0;
        chk("t4.accept_b", data_in, row_b);
        chk("t4.b_busy", DW'(busy), DW'(1));
        for (int k = 0; k < NF; k++) step();
        chk("t4.b_last_strobe", DW'(data_strobe), DW'(SW'(1) << (NF - 1)));
        accumn_fin = 1'b1;
        step();
        accumn_fin = 1'b0;
        step();
        chk("t4.row_cnt", DW'(row_cnt), DW'(2));

        // Test 5: drain timeout with accumn_fin tied low.
        do_reset(1);
        accept(row_c);
        for (int k = 0; k < NF; k++) step();
        for (int k = 0; k < 15; k++) step();
        chk("t5.err_before", DW'(err), DW'(0));
        chk("t5.busy_before", DW'(busy), DW'(1));
        step();
        chk("t5.err", DW'(err), DW'(1));
        chk("t5.busy_after", DW'(busy), DW'(0));
        chk("t5.row_cnt", DW'(row_cnt), DW'(0));
        accept(row_a);
        for (int k = 0; k < NF; k++) step();
        accumn_fin = 1'b1;
        step();
        accumn_fin = 1'b0;
        step();
        chk("t5.err_sticky", DW'(err), DW'(1));
        chk("t5.row_cnt_next", DW'(row_cnt), DW'(1));
        do_reset(1);
        chk("t5.err_cleared", DW'(err), DW'(0));

        // Test 6: reset mid-row, then a fresh row replays from bit0.
        accept(row_b);
        step(); step(); step();
        chk("t6.strobe_before", DW'(data_strobe), DW'(SW'(4)));
        rst = 1'b1;
        step();
        chk("t6.en_shift", DW'(en_shift), DW'(0));
        chk("t6.data_strobe", DW'(data_strobe), DW'(0));
        chk("t6.data_in", data_in, '0);
        chk("t6.busy", DW'(busy), DW'(0));
        chk("t6.s_ready_in_rst", DW'(s_ready), DW'(0));
        rst = 1'b0;
        #1;
        chk("t6.s_ready", DW'(s_ready), DW'(1));
        accept(row_c);
        step();
        chk("t6.replay_en", DW'(en_shift), DW'(1));
        chk("t6.replay_strobe", DW'(data_strobe), DW'(1));
        step();
        chk("t6.replay_strobe1", DW'(data_strobe), DW'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
